// File: rtl/instr_encoder_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader_pkg
//
// Purpose:
//   Shared MIPS encoding constants for the program loader. The op-class codes,
//   the opcode/funct values and the loader FSM state type all live here.
//   control_unit decodes the same values, so both sides agree on the
//   instruction set.
//
// Contents:
//   CLS_*        4-bit op-class codes presented on the loader's op bus
//   OPC_*        6-bit primary opcodes
//   FUNCT_*      6-bit R-type function codes
//   state_e      loader FSM states
//   pack_rtype   builds {000000, rs, rt, rd, 00000, funct}
//   pack_itype   builds {opcode, rs, rt, imm}
// ----------------------------------------------------------------------------
package instr_encoder_loader_pkg;

    // Op-class codes. Codes 9..14 are not assigned and are treated as illegal.
    localparam logic [3:0] CLS_ADD  = 4'd0;
    localparam logic [3:0] CLS_SUB  = 4'd1;
    localparam logic [3:0] CLS_AND  = 4'd2;
    localparam logic [3:0] CLS_OR   = 4'd3;
    localparam logic [3:0] CLS_NOR  = 4'd4;
    localparam logic [3:0] CLS_XOR  = 4'd5;
    localparam logic [3:0] CLS_ADDI = 4'd6;
    localparam logic [3:0] CLS_LW   = 4'd7;
    localparam logic [3:0] CLS_SW   = 4'd8;
    localparam logic [3:0] CLS_END  = 4'd15;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // R-type word. The shamt field is always zero for this op set.
    function automatic logic [31:0] pack_rtype(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] funct
    );
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    // I-type word. rd is not part of the format and is dropped.
    function automatic logic [31:0] pack_itype(
        input logic [5:0]  opcode,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opcode, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader_if
//
// Purpose:
//   Bundles the symbolic op handshake from the host with the instruction
//   memory write port. The loader sits on the slave side. The host/test
//   source, which also observes the imem writes, sits on the master side.
//
// Signals:
//   op_valid    host -> loader   op fields valid
//   op_ready    loader -> host   loader can accept an op this cycle
//   op_class    host -> loader   4-bit op class
//   op_rs       host -> loader   rs field
//   op_rt       host -> loader   rt field
//   op_rd       host -> loader   rd field (R-type only)
//   op_imm      host -> loader   immediate/offset (I-type only)
//   imem_we     loader -> imem   one-cycle write strobe
//   imem_addr   loader -> imem   word address of the write
//   imem_wdata  loader -> imem   encoded instruction
// ----------------------------------------------------------------------------
interface instr_encoder_loader_if #(
    parameter int ADDR_WIDTH = 6
) ();

    logic                  op_valid;
    logic                  op_ready;
    logic [3:0]            op_class;
    logic [4:0]            op_rs;
    logic [4:0]            op_rt;
    logic [4:0]            op_rd;
    logic [15:0]           op_imm;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    // Host side: drives ops, watches the handshake and the memory writes
    modport master (
        output op_valid, op_class, op_rs, op_rt, op_rd, op_imm,
        input  op_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side: consumes ops, drives the memory write port
    modport slave (
        input  op_valid, op_class, op_rs, op_rt, op_rd, op_imm,
        output op_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/instr_encoder_loader_encode.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader_encode
//
// Purpose:
//   Purely combinational translation of one symbolic op into a 32-bit MIPS
//   word. It also reports whether the class is writable (legal) and whether
//   the class is the END marker. END and illegal classes produce a zero word.
//
// Ports:
//   op_class_i  in   4   op class code
//   rs_i        in   5   rs field
//   rt_i        in   5   rt field
//   rd_i        in   5   rd field, used by R-type only
//   imm_i       in   16  immediate/offset, used by I-type only
//   word_o      out  32  encoded instruction
//   legal_o     out  1   class maps to a real instruction
//   is_end_o    out  1   class is the END marker
// ----------------------------------------------------------------------------
module instr_encoder_loader_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  op_class_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o,
    output logic        is_end_o
);

    // Class decode. R-type classes differ only in funct. I-type classes
    // differ only in opcode. Anything not listed stays illegal with a zero
    // word, so an unknown class can never reach memory by accident.
    always_comb begin
        word_o   = 32'h0000_0000;
        legal_o  = 1'b0;
        is_end_o = 1'b0;
        case (op_class_i)
            CLS_ADD: begin
                word_o  = pack_rtype(rs_i, rt_i, rd_i, FUNCT_ADD);
                legal_o = 1'b1;
            end
            CLS_SUB: begin
                word_o  = pack_rtype(rs_i, rt_i, rd_i, FUNCT_SUB);
                legal_o = 1'b1;
            end
            CLS_AND: begin
                word_o  = pack_rtype(rs_i, rt_i, rd_i, FUNCT_AND);
                legal_o = 1'b1;
            end
            CLS_OR: begin
                word_o  = pack_rtype(rs_i, rt_i, rd_i, FUNCT_OR);
                legal_o = 1'b1;
            end
            CLS_NOR: begin
                word_o  = pack_rtype(rs_i, rt_i, rd_i, FUNCT_NOR);
                legal_o = 1'b1;
            end
            CLS_XOR: begin
                word_o  = pack_rtype(rs_i, rt_i, rd_i, FUNCT_XOR);
                legal_o = 1'b1;
            end
            CLS_ADDI: begin
                word_o  = pack_itype(OPC_ADDI, rs_i, rt_i, imm_i);
                legal_o = 1'b1;
            end
            CLS_LW: begin
                word_o  = pack_itype(OPC_LW, rs_i, rt_i, imm_i);
                legal_o = 1'b1;
            end
            CLS_SW: begin
                word_o  = pack_itype(OPC_SW, rs_i, rt_i, imm_i);
                legal_o = 1'b1;
            end
            CLS_END: begin
                is_end_o = 1'b1;
            end
            default: begin
                word_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Accepts a stream of symbolic ops from a host, encodes each one into a MIPS
//   word, and writes the words to consecutive instruction-memory addresses
//   starting at 0. It holds the CPU off while a program is being loaded.
//
// Ports:
//   clk            in   1              rising-edge clock
//   reset          in   1              synchronous, active-high
//   start_i        in   1              begin a load (honoured in IDLE/DONE)
//   bus            slave modport       op handshake + imem write port
//   cpu_hold_o     out  1              keep the CPU stalled while high
//   busy_o         out  1              load in progress or write pending
//   done_o         out  1              level, high in DONE
//   full_o         out  1              sticky, last memory slot written
//   err_illegal_o  out  1              sticky, an illegal class was accepted
//   word_count_o   out  ADDR_WIDTH+1   words written during this load
// ----------------------------------------------------------------------------
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    instr_encoder_loader_if.slave bus,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  full_o,
    output logic                  err_illegal_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);

    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_e                state_q;
    logic [ADDR_WIDTH:0]   ptr_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  full_q;
    logic                  err_q;

    logic [31:0]           enc_word;
    logic                  enc_legal;
    logic                  enc_is_end;
    logic                  last_pending;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] write_addr_d;

    instr_encoder_loader_encode u_encode (
        .op_class_i (bus.op_class),
        .rs_i       (bus.op_rs),
        .rt_i       (bus.op_rt),
        .rd_i       (bus.op_rd),
        .imm_i      (bus.op_imm),
        .word_o     (enc_word),
        .legal_o    (enc_legal),
        .is_end_o   (enc_is_end)
    );

    // Handshake and address selection.
    // The pointer only advances once a write has actually gone out, so an op
    // accepted while the previous write is still on the bus must target
    // ptr+1. The same reasoning reserves the last slot. While the write to
    // the top address is in flight, nothing more may be accepted, even
    // though full is not set until that write completes.
    always_comb begin
        last_pending = we_q && (addr_q == MAX_ADDR);
        bus.op_ready = (state_q == ST_LOAD) && !full_q && !last_pending;
        accept       = bus.op_valid && bus.op_ready;
        write_addr_d = ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(we_q);
    end

    // Loader FSM together with the pointer and the registered write port.
    // A completing write and a new accept can share an edge. That is what
    // gives one word per cycle. END accepted during the final write can move
    // straight to DONE, because the write finishes on that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= '0;
                        full_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (we_q) begin
                        ptr_q <= ptr_q + CNT_ONE;
                        if (addr_q == MAX_ADDR) begin
                            full_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    if (accept) begin
                        if (enc_is_end) begin
                            state_q <= ST_DONE;
                        end else if (enc_legal) begin
                            we_q    <= 1'b1;
                            addr_q  <= write_addr_d;
                            wdata_q <= enc_word;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode. we_q is only ever set in LOAD, so busy reduces to the
    // LOAD state. The CPU hold therefore falls on the same edge that done
    // rises.
    always_comb begin
        bus.imem_we    = we_q;
        bus.imem_addr  = addr_q;
        bus.imem_wdata = wdata_q;
        busy_o         = (state_q == ST_LOAD);
        cpu_hold_o     = (state_q == ST_LOAD);
        done_o         = (state_q == ST_DONE);
        full_o         = full_q;
        err_illegal_o  = err_q;
        word_count_o   = ptr_q;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Purpose:
//   Drives two loaders. Instance A has a 64-word memory. Instance B has a
//   4-word memory, so the capacity limit can be reached quickly. Expected
//   words come from an arithmetic model of the MIPS field layout. Every
//   memory write seen on the bus is collected and compared with the model's
//   list of writes.
// ----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    typedef struct {
        int cls;
        int rs;
        int rt;
        int rd;
        int imm;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startA = 1'b0;
    logic        startB = 1'b0;
    logic        validA = 1'b0;
    logic        validB = 1'b0;
    logic [3:0]  opClass = '0;
    logic [4:0]  opRs = '0;
    logic [4:0]  opRt = '0;
    logic [4:0]  opRd = '0;
    logic [15:0] opImm = '0;

    logic       holdA, busyA, doneA, fullA, errA;
    logic [6:0] countA;
    logic       holdB, busyB, doneB, fullB, errB;
    logic [2:0] countB;

    int  testsRun = 0;
    int  testsFailed = 0;
    int  cyc = 0;
    wr_t obsA[$];
    wr_t obsB[$];
    wr_t expQ[$];

    instr_encoder_loader_if #(.ADDR_WIDTH(6)) busA ();
    instr_encoder_loader_if #(.ADDR_WIDTH(2)) busB ();

    assign busA.op_valid = validA;
    assign busA.op_class = opClass;
    assign busA.op_rs    = opRs;
    assign busA.op_rt    = opRt;
    assign busA.op_rd    = opRd;
    assign busA.op_imm   = opImm;
    assign busB.op_valid = validB;
    assign busB.op_class = opClass;
    assign busB.op_rs    = opRs;
    assign busB.op_rt    = opRt;
    assign busB.op_rd    = opRd;
    assign busB.op_imm   = opImm;

    instr_encoder_loader #(.ADDR_WIDTH(6)) dutA (
        .clk           (clk),
        .reset         (reset),
        .start_i       (startA),
        .bus           (busA.slave),
        .cpu_hold_o    (holdA),
        .busy_o        (busyA),
        .done_o        (doneA),
        .full_o        (fullA),
        .err_illegal_o (errA),
        .word_count_o  (countA)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2)) dutB (
        .clk           (clk),
        .reset         (reset),
        .start_i       (startB),
        .bus           (busB.slave),
        .cpu_hold_o    (holdB),
        .busy_o        (busyB),
        .done_o        (doneB),
        .full_o        (fullB),
        .err_illegal_o (errB),
        .word_count_o  (countB)
    );

    // Free-running clock and cycle counter used to time-stamp writes
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write monitors. These sample on the falling edge, well away from the
    // register updates.
    always @(negedge clk) begin
        if (busA.imem_we === 1'b1)
            obsA.push_back('{32'(busA.imem_addr), busA.imem_wdata, cyc});
        if (busB.imem_we === 1'b1)
            obsB.push_back('{32'(busB.imem_addr), busB.imem_wdata, cyc});
    end

    // Reference encoding built from the field layout with plain arithmetic.
    // The funct/opcode tables are indexed by class.
    function automatic logic [31:0] refEncode(input op_t o, output bit legal);
        int     functTab[6] = '{32, 34, 36, 37, 39, 38};
        int     opcTab[3]   = '{8, 35, 43};
        longint w;
        legal = 1'b1;
        if (o.cls >= 0 && o.cls <= 5)
            w = longint'(o.rs) * 2097152 + longint'(o.rt) * 65536
              + longint'(o.rd) * 2048 + longint'(functTab[o.cls]);
        else if (o.cls >= 6 && o.cls <= 8)
            w = longint'(opcTab[o.cls - 6]) * 67108864 + longint'(o.rs) * 2097152
              + longint'(o.rt) * 65536 + longint'(o.imm);
        else begin
            legal = 1'b0;
            w = 0;
        end
        return w[31:0];
    endfunction

    function automatic op_t mkOp(input int c, input int s, input int t, input int d, input int i);
        op_t o;
        o.cls = c; o.rs = s; o.rt = t; o.rd = d; o.imm = i;
        return o;
    endfunction

    function automatic op_t randOp(input bit allowIllegal);
        op_t o;
        o.cls = (allowIllegal && $urandom_range(0, 7) == 0) ? int'($urandom_range(9, 14))
                                                           : int'($urandom_range(0, 8));
        o.rs  = int'($urandom_range(0, 31));
        o.rt  = int'($urandom_range(0, 31));
        o.rd  = int'($urandom_range(0, 31));
        o.imm = int'($urandom_range(0, 65535));
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one op and waits (bounded) until the accepting edge has
    // passed. op_valid is left high so that the caller can stream the next
    // op or drop valid.
    task automatic applyStimulus(input bit useB, input op_t o);
        opClass = o.cls[3:0];
        opRs    = o.rs[4:0];
        opRt    = o.rt[4:0];
        opRd    = o.rd[4:0];
        opImm   = o.imm[15:0];
        if (useB) validB = 1'b1; else validA = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ((useB ? busB.op_ready : busA.op_ready) === 1'b1) break;
            step();
        end
        checkOutput("op_ready before accept", 32'(useB ? busB.op_ready : busA.op_ready), 32'd1);
        step();
    endtask

    task automatic waitDoneA();
        for (int k = 0; k < 40; k++) begin
            if (doneA === 1'b1) break;
            step();
        end
        checkOutput("done reached", 32'(doneA), 32'd1);
    endtask

    task automatic pulseStartA();
        startA = 1'b1;
        step();
        startA = 1'b0;
    endtask

    // Appends the model's writes for an op to expQ, at the next free address
    function automatic void modelOp(input op_t o, inout bit expErr);
        bit          legal;
        logic [31:0] w;
        w = refEncode(o, legal);
        if (legal) expQ.push_back('{32'(expQ.size()), w, 0});
        else expErr = 1'b1;
    endfunction

    // Compares the collected A-side writes with expQ
    task automatic compareWritesA(input string tag);
        checkOutput({tag, " write count"}, 32'(obsA.size()), 32'(expQ.size()));
        for (int i = 0; i < obsA.size() && i < expQ.size(); i++) begin
            checkOutput({tag, " addr"}, obsA[i].addr, expQ[i].addr);
            checkOutput({tag, " wdata"}, obsA[i].data, expQ[i].data);
        end
    endtask

    // Random load with gaps in the op stream. A start pulse is injected
    // inside a gap, and it must have no effect while the load is running.
    task automatic runRandomLoad(input int nOps);
        bit  expErr = 1'b0;
        op_t o;
        obsA.delete();
        expQ.delete();
        pulseStartA();
        checkOutput("rand load busy", 32'(busyA), 32'd1);
        checkOutput("rand load cpu_hold", 32'(holdA), 32'd1);
        checkOutput("rand flags cleared", {29'd0, doneA, fullA, errA}, 32'd0);
        checkOutput("rand count cleared", 32'(countA), 32'd0);
        for (int i = 0; i < nOps; i++) begin
            o = randOp(1'b1);
            modelOp(o, expErr);
            if ($urandom_range(0, 3) == 0) begin
                validA = 1'b0;
                startA = ($urandom_range(0, 1) == 1);
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) step();
                startA = 1'b0;
            end
            applyStimulus(1'b0, o);
        end
        applyStimulus(1'b0, mkOp(15, 0, 0, 0, 0));
        validA = 1'b0;
        waitDoneA();
        compareWritesA("rand");
        checkOutput("rand word_count", 32'(countA), 32'(expQ.size()));
        checkOutput("rand err_illegal", 32'(errA), 32'(expErr));
        checkOutput("rand full", 32'(fullA), 32'd0);
        checkOutput("rand cpu_hold after done", 32'(holdA), 32'd0);
    endtask

    initial begin
        op_t prog[$];
        bit  dummyErr;

        // Reset state
        reset = 1'b1;
        step();
        step();
        checkOutput("reset imem_we", 32'(busA.imem_we), 32'd0);
        checkOutput("reset imem_addr", 32'(busA.imem_addr), 32'd0);
        checkOutput("reset imem_wdata", busA.imem_wdata, 32'd0);
        checkOutput("reset op_ready", 32'(busA.op_ready), 32'd0);
        checkOutput("reset status", {27'd0, holdA, busyA, doneA, fullA, errA}, 32'd0);
        checkOutput("reset word_count", 32'(countA), 32'd0);
        reset = 1'b0;
        step();

        // Single ADD: the write appears one cycle after the accept
        obsA.delete();
        pulseStartA();
        checkOutput("start -> op_ready", 32'(busA.op_ready), 32'd1);
        applyStimulus(1'b0, mkOp(0, 9, 10, 8, 0));
        validA = 1'b0;
        checkOutput("add imem_we", 32'(busA.imem_we), 32'd1);
        checkOutput("add imem_addr", 32'(busA.imem_addr), 32'd0);
        checkOutput("add imem_wdata", busA.imem_wdata, 32'h012A4020);
        step();
        checkOutput("add we one cycle", 32'(busA.imem_we), 32'd0);
        checkOutput("add word_count", 32'(countA), 32'd1);
        applyStimulus(1'b0, mkOp(15, 0, 0, 0, 0));
        validA = 1'b0;
        waitDoneA();

        // Back-to-back stream from DONE: restarts at address 0, one word/cycle
        obsA.delete();
        pulseStartA();
        checkOutput("restart word_count", 32'(countA), 32'd0);
        checkOutput("restart done cleared", 32'(doneA), 32'd0);
        applyStimulus(1'b0, mkOp(6, 9, 8, 0, 100));
        applyStimulus(1'b0, mkOp(7, 29, 8, 0, 8));
        applyStimulus(1'b0, mkOp(8, 29, 9, 0, 12));
        applyStimulus(1'b0, mkOp(4, 15, 16, 14, 0));
        applyStimulus(1'b0, mkOp(15, 0, 0, 0, 0));
        validA = 1'b0;
        waitDoneA();
        expQ.delete();
        expQ.push_back('{32'd0, 32'h21280064, 0});
        expQ.push_back('{32'd1, 32'h8FA80008, 0});
        expQ.push_back('{32'd2, 32'hAFA9000C, 0});
        expQ.push_back('{32'd3, 32'h01F07027, 0});
        compareWritesA("stream");
        for (int i = 1; i < obsA.size(); i++)
            checkOutput("stream consecutive cycles", 32'(obsA[i].cyc - obsA[i-1].cyc), 32'd1);
        checkOutput("stream word_count", 32'(countA), 32'd4);
        checkOutput("stream cpu_hold", 32'(holdA), 32'd0);

        // Illegal class between two ADDs
        obsA.delete();
        pulseStartA();
        applyStimulus(1'b0, mkOp(0, 1, 2, 3, 0));
        applyStimulus(1'b0, mkOp(12, 4, 5, 6, 7));
        applyStimulus(1'b0, mkOp(0, 7, 8, 9, 0));
        applyStimulus(1'b0, mkOp(15, 0, 0, 0, 0));
        validA = 1'b0;
        waitDoneA();
        expQ.delete();
        dummyErr = 1'b0;
        modelOp(mkOp(0, 1, 2, 3, 0), dummyErr);
        modelOp(mkOp(12, 4, 5, 6, 7), dummyErr);
        modelOp(mkOp(0, 7, 8, 9, 0), dummyErr);
        compareWritesA("illegal");
        checkOutput("illegal err_illegal", 32'(errA), 32'd1);
        checkOutput("illegal word_count", 32'(countA), 32'd2);

        // Randomized loads, each checked against the model
        for (int r = 0; r < 5; r++) runRandomLoad(int'($urandom_range(6, 24)));

        // Capacity limit on the 4-word instance
        obsB.delete();
        prog.delete();
        startB = 1'b1;
        step();
        startB = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prog.push_back(randOp(1'b0));
            applyStimulus(1'b1, prog[i]);
        end
        checkOutput("cap 4th write addr", 32'(busB.imem_addr), 32'd3);
        checkOutput("cap op_ready during last write", 32'(busB.op_ready), 32'd0);
        opClass = 4'd0;
        step();
        checkOutput("cap full", 32'(fullB), 32'd1);
        checkOutput("cap done", 32'(doneB), 32'd1);
        checkOutput("cap word_count", 32'(countB), 32'd4);
        checkOutput("cap op_ready 5th", 32'(busB.op_ready), 32'd0);
        checkOutput("cap cpu_hold", 32'(holdB), 32'd0);
        step();
        step();
        validB = 1'b0;
        checkOutput("cap write count", 32'(obsB.size()), 32'd4);
        for (int i = 0; i < obsB.size() && i < 4; i++) begin
            bit lg;
            checkOutput("cap addr", obsB[i].addr, 32'(i));
            checkOutput("cap wdata", obsB[i].data, refEncode(prog[i], lg));
        end

        // Reset one cycle after an accept aborts the pending load
        pulseStartA();
        applyStimulus(1'b0, mkOp(1, 3, 4, 5, 0));
        validA = 1'b0;
        reset = 1'b1;
        step();
        checkOutput("abort imem_we", 32'(busA.imem_we), 32'd0);
        checkOutput("abort imem_addr", 32'(busA.imem_addr), 32'd0);
        checkOutput("abort imem_wdata", busA.imem_wdata, 32'd0);
        checkOutput("abort status", {27'd0, holdA, busyA, doneA, fullA, errA}, 32'd0);
        checkOutput("abort word_count", 32'(countA), 32'd0);
        reset = 1'b0;
        step();
        checkOutput("abort idle op_ready", 32'(busA.op_ready), 32'd0);
        checkOutput("abort idle imem_we", 32'(busA.imem_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
